// File: rtl/lif_neuron_multi.sv
// Leaky integrate-and-fire neuron with N_IN weighted synapses and a small
// writable config bank (weights, threshold, leak, refractory period, control).
module lif_neuron_multi #(
    parameter int unsigned N_IN  = 4,
    parameter int unsigned V_W   = 8,
    parameter int unsigned W_W   = 4,
    parameter int unsigned REF_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_IN-1:0]  spike_in,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [7:0]       cfg_data,
    output logic             spike_out,
    output logic             refractory,
    output logic [V_W-1:0]   v_mem,
    output logic [7:0]       spike_count
);

    localparam int unsigned S_W = V_W + 4;
    localparam logic [V_W-1:0] V_MAX = {V_W{1'b1}};
    localparam logic [3:0] ADDR_THRESH = 4'd8;
    localparam logic [3:0] ADDR_LEAK   = 4'd9;
    localparam logic [3:0] ADDR_REFRAC = 4'd10;
    localparam logic [3:0] ADDR_CTRL   = 4'd11;

    logic [V_W-1:0]   v_q, v_d;
    logic [REF_W-1:0] refr_q, refr_d;
    logic             spike_q, spike_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [W_W-1:0]   weight_q [N_IN];
    logic [W_W-1:0]   weight_d [N_IN];
    logic [7:0]       thresh_q, thresh_d;
    logic [7:0]       leak_q, leak_d;
    logic [REF_W-1:0] refrac_q, refrac_d;
    logic             mode_q, mode_d;

    logic [S_W-1:0]   integ;
    logic [V_W-1:0]   leaked;
    logic [S_W-1:0]   vn_wide;
    logic [V_W-1:0]   vn;
    logic             fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q      <= '0;
            refr_q   <= '0;
            spike_q  <= 1'b0;
            cnt_q    <= '0;
            thresh_q <= 8'd200;
            leak_q   <= 8'd1;
            refrac_q <= REF_W'(2);
            mode_q   <= 1'b0;
            for (int i = 0; i < int'(N_IN); i++) begin
                weight_q[i] <= W_W'(1);
            end
        end else begin
            v_q      <= v_d;
            refr_q   <= refr_d;
            spike_q  <= spike_d;
            cnt_q    <= cnt_d;
            thresh_q <= thresh_d;
            leak_q   <= leak_d;
            refrac_q <= refrac_d;
            mode_q   <= mode_d;
            weight_q <= weight_d;
        end
    end

    // Membrane datapath: leak first, then add synaptic input, then saturate.
    always_comb begin
        integ = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            if (spike_in[i]) begin
                integ = integ + S_W'(weight_q[i]);
            end
        end
        if (mode_q) begin
            leaked = v_q - (v_q >> leak_q[2:0]);
        end else if (v_q > V_W'(leak_q)) begin
            leaked = v_q - V_W'(leak_q);
        end else begin
            leaked = '0;
        end
        vn_wide = S_W'(leaked) + integ;
        vn      = (vn_wide > S_W'(V_MAX)) ? V_MAX : vn_wide[V_W-1:0];
        fire    = (vn >= V_W'(thresh_q));
    end

    // Next-state: neuron update, then config writes (clear strobe beats a fire).
    always_comb begin
        v_d      = v_q;
        refr_d   = refr_q;
        spike_d  = 1'b0;
        cnt_d    = cnt_q;
        thresh_d = thresh_q;
        leak_d   = leak_q;
        refrac_d = refrac_q;
        mode_d   = mode_q;
        weight_d = weight_q;

        if (ena) begin
            if (refr_q != '0) begin
                refr_d = refr_q - REF_W'(1);
                v_d    = '0;
            end else if (fire) begin
                spike_d = 1'b1;
                v_d     = '0;
                refr_d  = refrac_q;
                if (cnt_q != 8'hFF) begin
                    cnt_d = cnt_q + 8'd1;
                end
            end else begin
                v_d = vn;
            end
        end

        if (cfg_we) begin
            for (int i = 0; i < int'(N_IN); i++) begin
                if (cfg_addr == 4'(i)) begin
                    weight_d[i] = cfg_data[W_W-1:0];
                end
            end
            case (cfg_addr)
                ADDR_THRESH: thresh_d = cfg_data;
                ADDR_LEAK:   leak_d   = cfg_data;
                ADDR_REFRAC: refrac_d = cfg_data[REF_W-1:0];
                ADDR_CTRL: begin
                    mode_d = cfg_data[0];
                    if (cfg_data[1]) begin
                        cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign spike_out   = spike_q;
    assign refractory  = (refr_q != '0);
    assign v_mem       = v_q;
    assign spike_count = cnt_q;

endmodule
